ibex_instr_stim_seq: RTL and testbench

//  Programmable instruction-stream sequencer for decoder/ID-stage benches: replaces hard-coded per-cycle stimulus.

---
 rtl/ibex_instr_stim_seq.sv | 171 +++++++++++++++++
 tb/tb_ibex_instr_stim_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_instr_stim_seq.sv
// Programmable instruction-stream sequencer for decoder/ID-stage benches.
// Plays a DEPTH-entry instruction table one-shot, looped or LFSR-random, with hold and back-pressure.
module ibex_instr_stim_seq #(
    parameter int unsigned      DEPTH     = 16,
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] IDLE_INSN = 32'h0000_0013,
    parameter logic [15:0]      LFSR_SEED = 16'hACE1,
    localparam int unsigned     AW        = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_we_i,
    input  logic [AW-1:0]    cfg_addr_i,
    input  logic [WIDTH-1:0] cfg_wdata_i,
    input  logic [1:0]       cfg_flags_i,
    input  logic [AW-1:0]    cfg_last_i,
    input  logic [1:0]       mode_i,
    input  logic [15:0]      run_len_i,
    input  logic [3:0]       hold_cycles_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             instr_ready_i,
    output logic             instr_valid_o,
    output logic [WIDTH-1:0] instr_rdata_o,
    output logic [WIDTH-1:0] instr_rdata_alu_o,
    output logic             instr_first_cycle_o,
    output logic             illegal_c_insn_o,
    output logic             branch_taken_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      issue_cnt_o
);

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_e;

    localparam logic [1:0]  MODE_LOOP = 2'b01;
    localparam logic [1:0]  MODE_RAND = 2'b10;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [3:0]       hold_q, hold_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             stop_q, stop_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] tbl_insn_q [DEPTH];
    logic [1:0]       tbl_flag_q [DEPTH];

    logic [15:0]      lfsr_step;
    logic [15:0]      cnt_inc;
    logic             retire;
    logic             end_oneshot;
    logic             end_limit;
    logic             is_loop;
    logic             is_rand;

    // Random index folds out-of-range LFSR values back onto entry 0.
    function automatic logic [AW-1:0] rand_idx(input logic [15:0] v, input logic [AW-1:0] last);
        logic [AW-1:0] idx;
        idx = v[AW-1:0];
        if (idx > last) idx = '0;
        return idx;
    endfunction

    assign is_loop   = (mode_i == MODE_LOOP);
    assign is_rand   = (mode_i == MODE_RAND);
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // >= rather than == so a live decrease of hold_cycles_i below hold_q retires at once.
    assign retire    = (state_q == S_ISSUE) && instr_ready_i && (hold_q >= hold_cycles_i);

    // Reserved mode 11 falls through to one-shot behaviour.
    assign end_oneshot = !is_loop && !is_rand && (ptr_q >= cfg_last_i);
    assign end_limit   = (is_loop || is_rand) && (run_len_i != 16'd0) && (cnt_inc >= run_len_i);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        stop_d  = stop_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ISSUE;
                    ptr_d   = is_rand ? rand_idx(LFSR_SEED, cfg_last_i) : '0;
                    hold_d  = '0;
                    cnt_d   = '0;
                    lfsr_d  = LFSR_SEED;
                    stop_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                if (stop_i) stop_d = 1'b1;
                if (retire) begin
                    hold_d = '0;
                    cnt_d  = cnt_inc;
                    if (is_rand) begin
                        lfsr_d = lfsr_step;
                        ptr_d  = rand_idx(lfsr_step, cfg_last_i);
                    end else if (is_loop && (ptr_q >= cfg_last_i)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                    if (end_oneshot || end_limit || stop_q || stop_i) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (instr_ready_i) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end
    end

    // Table is writable at any time; the read side is combinational on ptr_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_insn_q[i] <= IDLE_INSN;
                tbl_flag_q[i] <= 2'b00;
            end
        end else if (cfg_we_i) begin
            tbl_insn_q[cfg_addr_i] <= cfg_wdata_i;
            tbl_flag_q[cfg_addr_i] <= cfg_flags_i;
        end
    end

    assign instr_valid_o       = (state_q == S_ISSUE);
    assign instr_rdata_o       = instr_valid_o ? tbl_insn_q[ptr_q] : IDLE_INSN;
    assign instr_rdata_alu_o   = instr_rdata_o;
    assign instr_first_cycle_o = instr_valid_o && (hold_q == 4'd0);
    assign illegal_c_insn_o    = instr_valid_o && tbl_flag_q[ptr_q][0];
    assign branch_taken_o      = instr_valid_o && tbl_flag_q[ptr_q][1];
    assign busy_o              = instr_valid_o;
    assign done_o              = done_q;
    assign issue_cnt_o         = cnt_q;

endmodule

// File: tb/tb_ibex_instr_stim_seq.sv
// Directed bench for ibex_instr_stim_seq: one task per scenario, inline checks against hand-derived values.
module tb_ibex_instr_stim_seq;

    localparam logic [31:0] SUB  = 32'h403100B3;
    localparam logic [31:0] AND  = 32'h0062F233;
    localparam logic [31:0] ADDI = 32'h00A00513;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cfg_we_i;
    logic [3:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [1:0]  cfg_flags_i;
    logic [3:0]  cfg_last_i;
    logic [1:0]  mode_i;
    logic [15:0] run_len_i;
    logic [3:0]  hold_cycles_i;
    logic        start_i;
    logic        stop_i;
    logic        instr_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_rdata_alu_o;
    logic        instr_first_cycle_o;
    logic        illegal_c_insn_o;
    logic        branch_taken_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] issue_cnt_o;

    int checks = 0;
    int errors = 0;

    ibex_instr_stim_seq dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .cfg_we_i           (cfg_we_i),
        .cfg_addr_i         (cfg_addr_i),
        .cfg_wdata_i        (cfg_wdata_i),
        .cfg_flags_i        (cfg_flags_i),
        .cfg_last_i         (cfg_last_i),
        .mode_i             (mode_i),
        .run_len_i          (run_len_i),
        .hold_cycles_i      (hold_cycles_i),
        .start_i            (start_i),
        .stop_i             (stop_i),
        .instr_ready_i      (instr_ready_i),
        .instr_valid_o      (instr_valid_o),
        .instr_rdata_o      (instr_rdata_o),
        .instr_rdata_alu_o  (instr_rdata_alu_o),
        .instr_first_cycle_o(instr_first_cycle_o),
        .illegal_c_insn_o   (illegal_c_insn_o),
        .branch_taken_o     (branch_taken_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .issue_cnt_o        (issue_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [1:0] f);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a[3:0];
        cfg_wdata_i = d;
        cfg_flags_i = f;
        tick();
        cfg_we_i    = 1'b0;
    endtask

    task automatic kick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    function automatic logic [31:0] tval(input int i);
        return 32'hA000_0000 | i;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; cfg_we_i = 0; cfg_addr_i = 0; cfg_wdata_i = 0; cfg_flags_i = 0;
        cfg_last_i = 0; mode_i = 0; run_len_i = 0; hold_cycles_i = 0;
        start_i = 0; stop_i = 0; instr_ready_i = 1;
        #3;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset valid got %b exp 0", instr_valid_o); end
        checks++; if (instr_rdata_o !== NOP) begin errors++; $display("FAIL reset rdata got %h exp %h", instr_rdata_o, NOP); end
        checks++; if (instr_rdata_alu_o !== NOP) begin errors++; $display("FAIL reset rdata_alu got %h exp %h", instr_rdata_alu_o, NOP); end
        checks++; if ({instr_first_cycle_o, illegal_c_insn_o, branch_taken_o, busy_o, done_o} !== 5'b0) begin
            errors++; $display("FAIL reset ctl got %b exp 00000", {instr_first_cycle_o, illegal_c_insn_o, branch_taken_o, busy_o, done_o}); end
        checks++; if (issue_cnt_o !== 16'd0) begin errors++; $display("FAIL reset cnt got %0d exp 0", issue_cnt_o); end
        tick(); tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_oneshot();
        logic [31:0] exp_d [2];
        logic [1:0]  exp_f [2];
        exp_d[0] = SUB; exp_d[1] = AND; exp_f[0] = 2'b01; exp_f[1] = 2'b10;
        wr(0, SUB, 2'b01);
        wr(1, AND, 2'b10);
        cfg_last_i = 1; mode_i = 2'b00; hold_cycles_i = 0; instr_ready_i = 1;
        kick();
        for (int c = 0; c < 2; c++) begin
            checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL oneshot valid c%0d got %b exp 1", c, instr_valid_o); end
            checks++; if (instr_rdata_o !== exp_d[c]) begin errors++; $display("FAIL oneshot rdata c%0d got %h exp %h", c, instr_rdata_o, exp_d[c]); end
            checks++; if (instr_first_cycle_o !== 1'b1) begin errors++; $display("FAIL oneshot first c%0d got %b exp 1", c, instr_first_cycle_o); end
            checks++; if ({branch_taken_o, illegal_c_insn_o} !== exp_f[c]) begin
                errors++; $display("FAIL oneshot flags c%0d got %b exp %b", c, {branch_taken_o, illegal_c_insn_o}, exp_f[c]); end
            tick();
        end
        checks++; if ({instr_valid_o, done_o} !== 2'b01) begin errors++; $display("FAIL oneshot done got v/d %b exp 01", {instr_valid_o, done_o}); end
        checks++; if (issue_cnt_o !== 16'd2) begin errors++; $display("FAIL oneshot cnt got %0d exp 2", issue_cnt_o); end
        tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL oneshot done pulse width got %b exp 0", done_o); end
        checks++; if (issue_cnt_o !== 16'd2) begin errors++; $display("FAIL oneshot cnt hold got %0d exp 2", issue_cnt_o); end
    endtask

    task automatic test_hold();
        hold_cycles_i = 2;
        kick();
        for (int c = 0; c < 6; c++) begin
            checks++; if (instr_rdata_o !== ((c < 3) ? SUB : AND)) begin
                errors++; $display("FAIL hold rdata c%0d got %h exp %h", c, instr_rdata_o, (c < 3) ? SUB : AND); end
            checks++; if (instr_first_cycle_o !== ((c % 3) == 0)) begin
                errors++; $display("FAIL hold first c%0d got %b exp %b", c, instr_first_cycle_o, (c % 3) == 0); end
            checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL hold early done c%0d", c); end
            tick();
        end
        checks++; if ({instr_valid_o, done_o} !== 2'b01) begin errors++; $display("FAIL hold done got v/d %b exp 01", {instr_valid_o, done_o}); end
        checks++; if (issue_cnt_o !== 16'd2) begin errors++; $display("FAIL hold cnt got %0d exp 2", issue_cnt_o); end
        tick();
    endtask

    task automatic test_stall();
        hold_cycles_i = 0; instr_ready_i = 0;
        kick();
        for (int c = 0; c < 3; c++) begin
            checks++; if (instr_rdata_o !== SUB) begin errors++; $display("FAIL stall rdata c%0d got %h exp %h", c, instr_rdata_o, SUB); end
            checks++; if (instr_first_cycle_o !== 1'b1) begin errors++; $display("FAIL stall first c%0d got %b exp 1", c, instr_first_cycle_o); end
            checks++; if (issue_cnt_o !== 16'd0) begin errors++; $display("FAIL stall cnt c%0d got %0d exp 0", c, issue_cnt_o); end
            if (c == 2) instr_ready_i = 1;
            tick();
        end
        checks++; if (instr_rdata_o !== AND) begin errors++; $display("FAIL stall resume rdata got %h exp %h", instr_rdata_o, AND); end
        checks++; if (issue_cnt_o !== 16'd1) begin errors++; $display("FAIL stall resume cnt got %0d exp 1", issue_cnt_o); end
        tick();
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL stall done got %b exp 1", done_o); end
        tick();
    endtask

    task automatic test_loop();
        logic [31:0] seq [7];
        seq[0] = SUB; seq[1] = AND; seq[2] = ADDI; seq[3] = SUB; seq[4] = AND; seq[5] = ADDI; seq[6] = SUB;
        wr(2, ADDI, 2'b00);
        cfg_last_i = 2; mode_i = 2'b01; run_len_i = 7;
        kick();
        for (int c = 0; c < 7; c++) begin
            checks++; if (instr_valid_o !== 1'b1 || instr_rdata_o !== seq[c]) begin
                errors++; $display("FAIL loop c%0d got v=%b %h exp v=1 %h", c, instr_valid_o, instr_rdata_o, seq[c]); end
            tick();
        end
        checks++; if ({instr_valid_o, done_o} !== 2'b01) begin errors++; $display("FAIL loop done got v/d %b exp 01", {instr_valid_o, done_o}); end
        checks++; if (issue_cnt_o !== 16'd7) begin errors++; $display("FAIL loop cnt got %0d exp 7", issue_cnt_o); end
        tick();
    endtask

    task automatic test_random();
        int idx15 [4];
        int idx7 [4];
        // Galois LFSR from ACE1: ACE1 -> E270 -> 7138 -> 389C; low nibbles 1,0,8,C.
        idx15[0] = 1; idx15[1] = 0; idx15[2] = 8; idx15[3] = 12;
        // With last=7 the values 8 and C exceed the range and fold to 0.
        idx7[0] = 1; idx7[1] = 0; idx7[2] = 0; idx7[3] = 0;
        for (int i = 0; i < 16; i++) wr(i, tval(i), i[1:0]);
        mode_i = 2'b10; run_len_i = 4; cfg_last_i = 15; hold_cycles_i = 0;
        kick();
        for (int c = 0; c < 4; c++) begin
            checks++; if (instr_rdata_o !== tval(idx15[c])) begin
                errors++; $display("FAIL rand15 c%0d got %h exp %h", c, instr_rdata_o, tval(idx15[c])); end
            tick();
        end
        checks++; if ({instr_valid_o, done_o} !== 2'b01 || issue_cnt_o !== 16'd4) begin
            errors++; $display("FAIL rand15 end got v/d %b cnt %0d exp 01 cnt 4", {instr_valid_o, done_o}, issue_cnt_o); end
        tick();
        cfg_last_i = 7;
        kick();
        for (int c = 0; c < 4; c++) begin
            checks++; if (instr_rdata_o !== tval(idx7[c])) begin
                errors++; $display("FAIL rand7 c%0d got %h exp %h", c, instr_rdata_o, tval(idx7[c])); end
            tick();
        end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL rand7 done got %b exp 1", done_o); end
        tick();
        // Unlimited run, stop pulsed on the first cycle of a 3-cycle hold.
        cfg_last_i = 15; run_len_i = 0; hold_cycles_i = 2;
        kick();
        stop_i = 1;
        tick();
        stop_i = 0;
        for (int c = 1; c < 3; c++) begin
            checks++; if (instr_valid_o !== 1'b1 || instr_rdata_o !== tval(1)) begin
                errors++; $display("FAIL stop c%0d got v=%b %h exp v=1 %h", c, instr_valid_o, instr_rdata_o, tval(1)); end
            tick();
        end
        checks++; if ({instr_valid_o, done_o} !== 2'b01 || issue_cnt_o !== 16'd1) begin
            errors++; $display("FAIL stop end got v/d %b cnt %0d exp 01 cnt 1", {instr_valid_o, done_o}, issue_cnt_o); end
        tick();
    endtask

    task automatic test_live_write();
        wr(0, SUB, 2'b00);
        mode_i = 2'b00; cfg_last_i = 0; hold_cycles_i = 2;
        kick();
        checks++; if (instr_rdata_o !== SUB) begin errors++; $display("FAIL live c0 got %h exp %h", instr_rdata_o, SUB); end
        cfg_we_i = 1; cfg_addr_i = 0; cfg_wdata_i = AND; cfg_flags_i = 2'b10; start_i = 1;
        tick();
        cfg_we_i = 0; start_i = 0;
        checks++; if (instr_rdata_o !== AND || branch_taken_o !== 1'b1 || instr_first_cycle_o !== 1'b0) begin
            errors++; $display("FAIL live c1 got %h br=%b fc=%b exp %h br=1 fc=0", instr_rdata_o, branch_taken_o, instr_first_cycle_o, AND); end
        tick(); tick();
        checks++; if ({instr_valid_o, done_o} !== 2'b01 || issue_cnt_o !== 16'd1) begin
            errors++; $display("FAIL live end got v/d %b cnt %0d exp 01 cnt 1", {instr_valid_o, done_o}, issue_cnt_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        wr(0, SUB, 2'b11);
        hold_cycles_i = 3; cfg_last_i = 0; mode_i = 2'b00;
        kick();
        tick();
        checks++; if (instr_rdata_o !== SUB || {branch_taken_o, illegal_c_insn_o} !== 2'b11) begin
            errors++; $display("FAIL rstmid pre got %h f=%b exp %h f=11", instr_rdata_o, {branch_taken_o, illegal_c_insn_o}, SUB); end
        #2 rst_ni = 0;
        #1;
        checks++; if ({instr_valid_o, busy_o, instr_first_cycle_o, illegal_c_insn_o, branch_taken_o} !== 5'b0
                      || instr_rdata_o !== NOP || issue_cnt_o !== 16'd1 - 16'd1) begin
            errors++; $display("FAIL rstmid outputs got v=%b b=%b rd=%h cnt=%0d exp 0 0 %h 0", instr_valid_o, busy_o, instr_rdata_o, issue_cnt_o, NOP); end
        tick();
        rst_ni = 1; hold_cycles_i = 0;
        tick();
        kick();
        checks++; if (instr_rdata_o !== NOP || {branch_taken_o, illegal_c_insn_o} !== 2'b00) begin
            errors++; $display("FAIL rstmid table got %h f=%b exp %h f=00", instr_rdata_o, {branch_taken_o, illegal_c_insn_o}, NOP); end
        tick();
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL rstmid done got %b exp 1", done_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_hold();
        test_stall();
        test_loop();
        test_random();
        test_live_write();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
